// File: rtl/button_in_pkg.sv
// Shared layout of the button status word and counter sizing helper for the
// push-button input port.
package button_in_pkg;

  localparam int LEVEL_LSB  = 0;
  localparam int FLAG_LSB   = 16;
  localparam int MAX_WIDTH  = 16;
  localparam int DATA_WIDTH = 32;

  // Status word as seen by the CPU: press flags in the upper half, levels below.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] flags;
    logic [MAX_WIDTH-1:0] level;
  } status_t;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/button_in_debounce_bit.sv
// One input bit: polarity normalize, 2-flop synchronize, then accept a level
// change only after DEBOUNCE_CYCLES consecutive mismatching samples.
module button_in_debounce_bit
  import button_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pin_n;
  logic             sync1_q, sync1_d;
  logic             sync0_q, sync0_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  assign pin_n = ACTIVE_LOW ? ~pin : pin;

  always_comb begin
    sync1_d  = pin_n;
    sync0_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    // Any sample matching the accepted level restarts the count.
    if (sync0_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        accept   = 1'b1;
        stable_d = sync0_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Combinational so the top-level flag and pulse register on the same edge as stable.
  assign rise   = accept & sync0_q;
  assign stable = stable_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync0_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync0_q  <= sync0_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/button_in.sv
// Push-button / DIP-switch input port: per-bit debounce, sticky press flags
// cleared by CPU write, and a 32-bit status word for the I/O read mux.
module button_in
  import button_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             ext_button,
  input  logic                         clear_we,
  input  logic [WIDTH-1:0]             clear_mask,
  output logic signed [DATA_WIDTH-1:0] data,
  output logic [WIDTH-1:0]             press_pulse
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] pressed_q, pressed_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  status_t          status;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_in_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .pin   (ext_button[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  // Rise is OR'd after the clear so a same-cycle press keeps its flag.
  always_comb begin
    clear_bits = clear_we ? clear_mask : '0;
    pressed_d  = (pressed_q & ~clear_bits) | rise;
    pulse_d    = rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_q <= '0;
      pulse_q   <= '0;
    end else begin
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
    end
  end

  always_comb begin
    status                    = '0;
    status.level[WIDTH-1:0]   = stable;
    status.flags[WIDTH-1:0]   = pressed_q;
  end

  assign data        = $signed(status);
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_in.sv
// Directed bench for button_in with a short debounce window (4 cycles).
module tb_button_in;

  logic               clk;
  logic               reset;
  logic [3:0]         ext_button;
  logic               clear_we;
  logic [3:0]         clear_mask;
  logic signed [31:0] data;
  logic [3:0]         press_pulse;

  int checks;
  int errors;

  button_in #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_button (ext_button),
    .clear_we   (clear_we),
    .clear_mask (clear_mask),
    .data       (data),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  btn;
    logic        cw;
    logic [3:0]  cm;
    logic [31:0] exp_data;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [3:0] btn, input logic cw,
                     input logic [3:0] cm, input logic [31:0] ed, input logic [3:0] ep);
    vec_t v;
    v.rst = rst; v.btn = btn; v.cw = cw; v.cm = cm; v.exp_data = ed; v.exp_pulse = ep;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [3:0] btn, input logic [31:0] ed);
    for (int k = 0; k < n; k++) add(1'b0, btn, 1'b0, 4'h0, ed, 4'h0);
  endtask

  task automatic check(input string name, input logic [31:0] ed, input logic [3:0] ep);
    checks++;
    if (data !== ed || press_pulse !== ep) begin
      errors++;
      $display("FAIL %s: data=%h pulse=%b, required data=%h pulse=%b",
               name, data, press_pulse, ed, ep);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    ext_button = 4'hF;
    clear_we   = 1'b0;
    clear_mask = 4'h0;

    // Vector table: inputs applied at negedge, outputs checked just after posedge.
    add(1'b1, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0);
    for (int r = 0; r < 2; r++) begin
      add_n(3, 4'hD, 32'h0);
      add_n(3, 4'hF, 32'h0);
    end
    add_n(5, 4'hB, 32'h0);
    add(1'b0, 4'hB, 1'b0, 4'h0, 32'h0004_0004, 4'b0100);
    add_n(5, 4'hF, 32'h0004_0004);
    add_n(2, 4'hF, 32'h0004_0000);
    add_n(5, 4'hE, 32'h0004_0000);
    add(1'b0, 4'hE, 1'b0, 4'h0, 32'h0005_0001, 4'b0001);
    add(1'b0, 4'hE, 1'b1, 4'b0001, 32'h0004_0001, 4'h0);
    add(1'b0, 4'hE, 1'b1, 4'b0000, 32'h0004_0001, 4'h0);
    add(1'b0, 4'hE, 1'b0, 4'b0000, 32'h0004_0001, 4'h0);
    add(1'b0, 4'hE, 1'b1, 4'b0010, 32'h0004_0001, 4'h0);
    add_n(5, 4'h6, 32'h0004_0001);
    add(1'b0, 4'h6, 1'b1, 4'b1000, 32'h000C_0009, 4'b1000);
    add(1'b0, 4'h6, 1'b0, 4'b0000, 32'h000C_0009, 4'h0);
    add(1'b1, 4'hF, 1'b0, 4'h0, 32'h0, 4'h0);
    add_n(5, 4'h0, 32'h0);
    add(1'b0, 4'h0, 1'b0, 4'h0, 32'h000F_000F, 4'b1111);
    add(1'b0, 4'h0, 1'b0, 4'h0, 32'h000F_000F, 4'h0);

    // Hand sequence: asynchronous mid-cycle reset while bit0 is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset      = 1'b0;
    ext_button = 4'hE;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("pre_accept", 32'h0, 4'h0);
    end
    @(posedge clk); #1;
    check("first_accept", 32'h0001_0001, 4'b0001);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 32'h0, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check("redebounce_wait", 32'h0, 4'h0);
    end
    @(posedge clk); #1;
    check("redebounce_accept", 32'h0001_0001, 4'b0001);
    @(posedge clk); #1;
    check("redebounce_pulse_end", 32'h0001_0001, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset      = vecs[i].rst;
      ext_button = vecs[i].btn;
      clear_we   = vecs[i].cw;
      clear_mask = vecs[i].cm;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_pulse);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_in.md
# button_in

Input-side counterpart of the hex LED output port: samples the board's push-buttons/DIP switches, synchronizes and debounces each bit, and presents a 32-bit status word (debounced level plus sticky "pressed" flags) to the CPU data bus. Sits between the external pins and the I/O read mux. The CPU clears individual press flags with a write strobe.

## Interface
Parameters:
- WIDTH, 4: number of input bits, 1..16.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a level change is accepted, ≥ 2.
- ACTIVE_LOW, 1: 1 means pins read 0 when pressed; inverted before synchronization.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ext_button  in  WIDTH  raw pin inputs, asynchronous to clk.
- clear_we  in  1  write strobe, one cycle.
- clear_mask  in  WIDTH  bits to clear in the press flags when clear_we=1.
- data  out signed 32  status word: [WIDTH-1:0] debounced level, [16+WIDTH-1:16] press flags, all other bits 0.
- press_pulse  out  WIDTH  one-cycle pulse per bit on accepted press.

## Operation
- Per bit: polarity normalize (invert if ACTIVE_LOW), so 1 means pressed everywhere downstream.
- 2-flop synchronizer: sync1 <= pin, sync0 <= sync1.
- Debounce counter cnt, width clog2(DEBOUNCE_CYCLES):
  - sync0 == stable: cnt <= 0.
  - sync0 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync0 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync0, cnt <= 0 (accept).
  - Any glitch returning sync0 to stable before acceptance restarts the count from 0.
- rise = accept & sync0 (0→1 transition). Falling acceptances never set flags.
- Press flags: pressed <= (pressed & ~(clear_we ? clear_mask : 0)) | rise. Simultaneous clear and rise on the same bit: set wins (flag stays 1).
- press_pulse <= rise (registered), high exactly one cycle.
- clear_we with clear_mask=0 is a no-op; clear of a flag already 0 is a no-op.
- data is a pure wiring of registered state; no combinational path from ext_button or clear inputs.

## Timing
- Reset: sync flops, stable, cnt, pressed, press_pulse all 0; data = 0. Reset mid-debounce discards the count; after release an already-held button is re-debounced and generates a fresh press.
- Latency, pin edge to stable/pressed/press_pulse visible on outputs: 2 synchronizer cycles + DEBOUNCE_CYCLES cycles of mismatch, i.e. outputs change at the (DEBOUNCE_CYCLES+2)th rising edge after the first edge that samples the new pin level (±1 cycle for metastability resolution).
- stable bit, pressed bit and press_pulse change on the same clock edge.
- clear: flag reads 0 on data the cycle after the clear_we edge.
- Bits are fully independent; simultaneous presses on several bits set all flags on their own accept edges.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

## Structure
- Shared package button_in_pkg: field offsets LEVEL_LSB=0, FLAG_LSB=16, MAX_WIDTH=16, and a clog2 function for counter sizing.
- Sub-module debounce_bit (synchronizer + counter + stable + rise output), instantiated WIDTH times via generate; top level owns press flags, clear logic, press_pulse and data packing.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4, WIDTH=4, ACTIVE_LOW=1.)
- Reset check: assert reset asynchronously mid-cycle with ext_button=4'b1110 -> data=0, press_pulse=0 immediately; after release bit0 accepted 6 cycles later -> data=32'h0001_0001, one-cycle press_pulse=4'b0001.
- Glitch rejection: drive bit1 low for 3 cycles then high, repeat -> data stays 0, no press_pulse.
- Release: hold bit2 pressed until accepted, then release -> level bit2 returns to 0 after 6 cycles, flag bit18 stays 1, no pulse on release.
- Clear: flags = 4'b0101, clear_we with clear_mask=4'b0001 -> next cycle data[19:16]=4'b0100; clear_mask=0 -> unchanged.
- Set-wins collision: clear_we with clear_mask=4'b1000 on the exact accept cycle of bit3 press -> data[19]=1, press_pulse[3]=1.
- Simultaneous presses: all four bits pressed together -> single cycle with press_pulse=4'b1111, data=32'h000F_000F.
